// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer: set mm:ss in IDLE, count down on en_1, alarm at 00:00.
// Latency: raw button to state change is 4 clk edges (2-FF sync, history FF, registered edge pulse).
// No flow control: en_1 ticks and button edges are consumed in the cycle they appear.
module countdown_timer #(
    parameter int MAX_MIN    = 99,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_1,
    input  logic       adjust,
    input  logic       sel_min,
    input  logic       up,
    input  logic       down,
    input  logic       start,
    input  logic       clear,
    output logic [6:0] min_bin,
    output logic [5:0] sec_bin,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int              CW         = $clog2(ALARM_SECS + 1);
    localparam logic [6:0]      MIN_TOP    = 7'(MAX_MIN);
    localparam logic [5:0]      SEC_TOP    = 6'd59;
    localparam logic [CW-1:0]   ALARM_LAST = CW'(ALARM_SECS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] alarm_cnt;

    // Button pipeline, bit order {start, down, up}: two sync stages, one history stage,
    // and a registered rising-edge pulse so a held button yields a single edge.
    logic [2:0] btn_s1;
    logic [2:0] btn_s2;
    logic [2:0] btn_s3;
    logic [2:0] btn_edge;

    logic up_e;
    logic down_e;
    logic start_e;

    assign up_e    = btn_edge[0];
    assign down_e  = btn_edge[1];
    assign start_e = btn_edge[2];

    // Button conditioning plus the timer FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_s3    <= '0;
            btn_edge  <= '0;
            state     <= S_IDLE;
            min_bin   <= '0;
            sec_bin   <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            btn_s1   <= {start, down, up};
            btn_s2   <= btn_s1;
            btn_s3   <= btn_s2;
            btn_edge <= btn_s2 & ~btn_s3;
            done     <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (start_e && (min_bin != '0 || sec_bin != '0)) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end else if (adjust && (up_e ^ down_e)) begin
                        // Fields wrap independently; no carry or borrow while setting.
                        if (sel_min) begin
                            if (up_e) min_bin <= (min_bin == MIN_TOP) ? 7'd0 : min_bin + 7'd1;
                            else      min_bin <= (min_bin == 7'd0) ? MIN_TOP : min_bin - 7'd1;
                        end else begin
                            if (up_e) sec_bin <= (sec_bin == SEC_TOP) ? 6'd0 : sec_bin + 6'd1;
                            else      sec_bin <= (sec_bin == 6'd0) ? SEC_TOP : sec_bin - 6'd1;
                        end
                    end
                end

                S_RUN: begin
                    // A start edge pauses and swallows a coincident tick.
                    if (start_e) begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end else if (en_1) begin
                        if (sec_bin != 6'd0) begin
                            sec_bin <= sec_bin - 6'd1;
                            if (sec_bin == 6'd1 && min_bin == 7'd0) begin
                                state     <= S_DONE;
                                running   <= 1'b0;
                                done      <= 1'b1;
                                alarm     <= 1'b1;
                                alarm_cnt <= '0;
                            end
                        end else if (min_bin != 7'd0) begin
                            sec_bin <= SEC_TOP;
                            min_bin <= min_bin - 7'd1;
                        end
                    end
                end

                S_PAUSE: begin
                    if (start_e) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Acknowledge or timeout returns to IDLE without launching a new run.
                    if (start_e) begin
                        state     <= S_IDLE;
                        alarm     <= 1'b0;
                        alarm_cnt <= '0;
                    end else if (en_1) begin
                        if (alarm_cnt == ALARM_LAST) begin
                            state     <= S_IDLE;
                            alarm     <= 1'b0;
                            alarm_cnt <= '0;
                        end else begin
                            alarm_cnt <= alarm_cnt + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes expected snapshots from a
// total-seconds reference model, a monitor pops and compares them on falling edges.
module tb_countdown_timer;

    localparam int MAX_MIN    = 99;
    localparam int ALARM_SECS = 30;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_1 = 1'b0;
    logic       adjust = 1'b0;
    logic       sel_min = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] min_bin;
    logic [5:0] sec_bin;
    logic       running;
    logic       done;
    logic       alarm;

    countdown_timer #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_1    (en_1),
        .adjust  (adjust),
        .sel_min (sel_min),
        .up      (up),
        .down    (down),
        .start   (start),
        .clear   (clear),
        .min_bin (min_bin),
        .sec_bin (sec_bin),
        .running (running),
        .done    (done),
        .alarm   (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    mins;
        int    secs;
        bit    run;
        bit    alm;
        int    dcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    // Reference model state
    int m_min = 0, m_sec = 0, m_state = M_IDLE, m_acnt = 0, m_done = 0;

    function automatic void push_exp(input string tag);
        exp_q.push_back('{tag, m_min, m_sec, m_state == M_RUN, m_state == M_DONE, m_done});
    endfunction

    function automatic void model_zero();
        m_min = 0; m_sec = 0; m_state = M_IDLE; m_acnt = 0;
    endfunction

    function automatic void model_press(input bit u, input bit d, input bit st);
        if (st) begin
            case (m_state)
                M_IDLE:  if (m_min != 0 || m_sec != 0) m_state = M_RUN;
                M_RUN:   m_state = M_PAUSE;
                M_PAUSE: m_state = M_RUN;
                default: begin m_state = M_IDLE; m_acnt = 0; end
            endcase
        end else if (m_state == M_IDLE && adjust && (u != d)) begin
            if (sel_min) m_min = (m_min + (u ? 1 : MAX_MIN)) % (MAX_MIN + 1);
            else         m_sec = (m_sec + (u ? 1 : 59)) % 60;
        end
    endfunction

    function automatic void model_tick();
        int t;
        if (m_state == M_RUN) begin
            t = m_min * 60 + m_sec - 1;
            m_min = t / 60;
            m_sec = t % 60;
            if (t == 0) begin
                m_state = M_DONE;
                m_acnt = 0;
                m_done++;
            end
        end else if (m_state == M_DONE) begin
            m_acnt++;
            if (m_acnt == ALARM_SECS) begin
                m_state = M_IDLE;
                m_acnt = 0;
            end
        end
    endfunction

    // Monitor: done-pulse checks every cycle, snapshot compare whenever one is queued.
    initial begin
        bit   prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_seen++;
                checks++;
                if (prev_done || !alarm || running) begin
                    errors++;
                    $display("FAIL done_pulse: prev_done=%0b alarm=%0b running=%0b, required 0/1/0",
                             prev_done, alarm, running);
                end
            end
            prev_done = done;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (min_bin != e.mins || sec_bin != e.secs || running != e.run ||
                    alarm != e.alm || done_seen != e.dcnt) begin
                    errors++;
                    $display("FAIL %s: got %0d:%0d run=%0b alarm=%0b dones=%0d, required %0d:%0d run=%0b alarm=%0b dones=%0d",
                             e.tag, min_bin, sec_bin, running, alarm, done_seen,
                             e.mins, e.secs, e.run, e.alm, e.dcnt);
                end
            end
        end
    end

    task automatic press(input bit u, input bit d, input bit st, input string tag);
        @(negedge clk);
        up = u; down = d; start = st;
        repeat (6) @(negedge clk);
        up = 1'b0; down = 1'b0; start = 1'b0;
        repeat (6) @(negedge clk);
        model_press(u, d, st);
        push_exp(tag);
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        en_1 = 1'b1;
        @(negedge clk);
        en_1 = 1'b0;
        model_tick();
        push_exp(tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_zero();
        push_exp(tag);
    endtask

    task automatic set_mode(input bit adj, input bit sm);
        @(negedge clk);
        adjust = adj;
        sel_min = sm;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with button activity that must be discarded.
        rst_n = 1'b0;
        adjust = 1'b1;
        repeat (2) @(negedge clk);
        up = 1'b1; start = 1'b1;
        repeat (4) @(negedge clk);
        up = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        repeat (6) @(negedge clk);
        push_exp("reset");

        // Adjust wrap behaviour.
        set_mode(1, 0);
        press(0, 1, 0, "sec_wrap_down");
        set_mode(1, 1);
        press(0, 1, 0, "min_wrap_down");
        press(1, 0, 0, "min_wrap_up");
        press(1, 1, 0, "up_down_same");

        // Edge must not act within two clocks of the raw rise.
        @(negedge clk);
        up = 1'b1;
        repeat (2) @(negedge clk);
        push_exp("edge_latency");
        repeat (4) @(negedge clk);
        up = 1'b0;
        repeat (6) @(negedge clk);
        model_press(1, 0, 0);
        push_exp("edge_latency_done");

        // Borrow run from 02:00 down to DONE, then alarm timeout.
        do_clear("clear_idle");
        set_mode(1, 1);
        press(1, 0, 0, "set_min1");
        press(1, 0, 0, "set_min2");
        set_mode(0, 0);
        press(0, 0, 1, "start_0200");
        tick("borrow_0159");
        for (int i = 0; i < 119; i++) tick("countdown");
        for (int i = 0; i < ALARM_SECS; i++) tick("alarm_timeout");

        // Clear mid-RUN at 01:30.
        set_mode(1, 1);
        press(1, 0, 0, "set_0100");
        set_mode(1, 0);
        for (int i = 0; i < 30; i++) press(0, 1, 0, "set_secs");
        set_mode(0, 0);
        press(0, 0, 1, "start_0130");
        do_clear("clear_mid_run");

        // Pause/tick collision at 00:10.
        set_mode(1, 0);
        for (int i = 0; i < 10; i++) press(1, 0, 0, "set_0010");
        set_mode(0, 0);
        press(0, 0, 1, "start_0010");
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        en_1 = 1'b1;
        @(negedge clk);
        en_1 = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clk);
        model_press(0, 0, 1);
        push_exp("collision_pause");
        for (int i = 0; i < 5; i++) tick("paused_tick");
        press(0, 0, 1, "resume");
        tick("resume_0009");

        // Acknowledge 3 ticks into DONE.
        do_clear("clear_ack");
        set_mode(1, 0);
        press(1, 0, 0, "set_0001");
        press(1, 0, 0, "set_0002");
        set_mode(0, 0);
        press(0, 0, 1, "start_0002");
        tick("run_0001");
        tick("reach_done");
        for (int i = 0; i < 3; i++) tick("done_tick");
        press(0, 0, 1, "ack");
        tick("after_ack");

        // Zero start ignored; held button gives one step.
        press(0, 0, 1, "zero_start");
        set_mode(1, 0);
        @(negedge clk);
        up = 1'b1;
        repeat (1000) @(negedge clk);
        up = 1'b0;
        repeat (6) @(negedge clk);
        model_press(1, 0, 0);
        push_exp("hold_up");

        // Randomized operation mix.
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 7) begin
                int k;
                k = $urandom_range(1, 20);
                for (int i = 0; i < k; i++) tick("rnd_tick");
            end else if (op < 10) press(1, 0, 0, "rnd_up");
            else if (op < 12) press(0, 1, 0, "rnd_down");
            else if (op < 16) press(0, 0, 1, "rnd_start");
            else if (op < 17) press(1, 1, 0, "rnd_both");
            else if (op < 19) begin
                set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                push_exp("rnd_mode");
            end else do_clear("rnd_clear");
        end

        // Drain scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Minutes:seconds countdown timer for the clock. It is the borrow-direction counterpart of the minute/second up-counters.
- Counts down from a user-set mm:ss to 00:00 on the shared 1 Hz tick, borrowing from minutes into seconds, then raises an alarm.
- Uses the same up/down/adjust button scheme as the time-setting path, but sampled and edge-detected on a single system clock.
- Outputs feed the existing display mux as binary fields.

Parameters:
- MAX_MIN, 99, highest settable minute value (6-bit field is enough up to 63; width grows to 7 bits at the default).
- ALARM_SECS, 30, number of en_1 ticks the alarm stays asserted before auto-clear.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  synchronous active-low reset
- en_1  input  1  1 Hz tick, one clk cycle wide, already in the clk domain
- adjust  input  1  level; 1 = setting mode (effective only in IDLE)
- sel_min  input  1  level; field selected while adjusting: 1 = minutes, 0 = seconds
- up  input  1  raw button, asynchronous
- down  input  1  raw button, asynchronous
- start  input  1  raw button, asynchronous; start/pause/acknowledge
- clear  input  1  synchronous clear, level, clk domain
- min_bin  output  7  remaining minutes, binary 0..MAX_MIN
- sec_bin  output  6  remaining seconds, binary 0..59
- running  output  1  high in RUN
- done  output  1  one-cycle pulse on reaching 00:00
- alarm  output  1  high in DONE

Behaviour:
- Reset (rst_n=0 at a clk edge) and clear=1 have the same effect: state IDLE, min_bin=0, sec_bin=0, running=0, done=0, alarm=0, alarm counter=0, synchronizers=0. rst_n has priority over clear.
- Button conditioning: up, down and start each pass through a 2-FF synchronizer plus a rising-edge detector. An "edge" is a one-clk pulse, and it is not seen earlier than 3 clk cycles after the raw rise. A held button produces exactly one edge.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - With adjust=1, an up edge increments the selected field and a down edge decrements it.
  - Seconds wrap 59->0 and 0->59. Minutes wrap MAX_MIN->0 and 0->MAX_MIN. There is no borrow or carry between fields while adjusting.
  - Up and down edges in the same cycle: no change.
  - Start edge with value != 00:00 -> RUN. Start edge with value 00:00 is ignored.
  - With adjust=0, up/down edges are ignored.
- RUN (running=1):
  - On each en_1: if sec_bin>0, sec_bin-1. Otherwise, if min_bin>0, sec_bin=59 and min_bin-1.
  - The tick that produces 00:00 moves to DONE in the same clk edge. done pulses in the following cycle (registered), and alarm=1 from the cycle after that edge.
  - Start edge -> PAUSE. If a start edge and en_1 arrive in the same cycle, the start edge wins and that tick is discarded.
  - adjust, up and down are ignored.
- PAUSE: value frozen. en_1, adjust, up and down are ignored. Start edge -> RUN.
- DONE:
  - alarm=1; value held at 00:00.
  - The alarm counter increments on each en_1. When it reaches ALARM_SECS, or on a start edge (whichever comes first), go to IDLE with alarm=0 and counter=0.
  - A start edge used to acknowledge does not also start a new run.
- Clear mid-RUN or mid-DONE aborts immediately to IDLE 00:00 with no done pulse.
- done fires exactly once per countdown. It never fires on clear, reset or acknowledge.
- Width rules: arithmetic is done in field width with explicit wrap compares. No out-of-range value (sec>59, min>MAX_MIN) is ever produced.

Test Plan:
- Reset/clear: drive up/start edges during rst_n=0 -> all outputs 0, state IDLE. Repeat with clear=1 mid-RUN at 01:30 -> 00:00, running=0, no done pulse.
- Adjust wrap: IDLE, adjust=1, sel_min=0, one down edge from 00:00 -> sec_bin=59. Then sel_min=1, one down edge -> min_bin=99. One up edge -> min_bin=0. Simultaneous up and down edges -> unchanged.
- Borrow: set 02:00, start, 1 en_1 -> 01:59. Another 119 ticks -> 00:00, done high exactly 1 cycle, alarm=1, running=0.
- Pause/tick collision: RUN at 00:10, start edge and en_1 in the same cycle -> PAUSE at 00:10. 5 ticks -> still 00:10. Start edge -> RUN, next tick -> 00:09.
- Alarm timeout/ack: reach DONE; 30 en_1 ticks -> alarm=0, IDLE. Second run: start edge 3 ticks into DONE -> alarm=0, IDLE, running stays 0.
- Zero start and button hold: start edge at 00:00 -> stays IDLE. Hold up high for 1000 clk with adjust=1 -> field increments by exactly 1.
